// File: rtl/vrf_seq.sv
// Vector register file sequencer: accepts one element-wise op, walks read beats
// through the VRF read ports and replays matching write controls lat_p cycles later.
module vrf_seq #(
  parameter int els_p   = 32,
  parameter int vlen_p  = 8,
  parameter int lanes_p = 4,
  parameter int lat_p   = 2,
  localparam int VaW    = $clog2(els_p),
  localparam int LaW    = $clog2(vlen_p),
  localparam int VlW    = $clog2(vlen_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              v_i,
  output logic                              ready_o,
  input  logic [VaW-1:0]                    vd_i,
  input  logic [VaW-1:0]                    vs1_i,
  input  logic [VaW-1:0]                    vs2_i,
  input  logic [VlW-1:0]                    vl_i,
  output logic [VaW-1:0]                    r_reg0_addr_o,
  output logic [VaW-1:0]                    r_reg1_addr_o,
  output logic [lanes_p-1:0][LaW-1:0]       r_addr_o,
  output logic [lanes_p-1:0]                rd_v_o,
  output logic [VaW-1:0]                    w_reg_addr_o,
  output logic [lanes_p-1:0][LaW-1:0]       w_addr_o,
  output logic [lanes_p-1:0]                w_en_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [1:0]                        dbg_state_o
);

  localparam int Beats = vlen_p / lanes_p;
  localparam int KW    = (Beats > 1) ? $clog2(Beats) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [KW-1:0]                     r_k;
  logic [KW-1:0]                     r_last_k;
  logic [VlW-1:0]                    r_vl;
  logic [VaW-1:0]                    r_vd;
  logic [VaW-1:0]                    r_vs1;
  logic [VaW-1:0]                    r_vs2;
  logic [lanes_p-1:0]                r_rd_v;
  logic [lanes_p-1:0][LaW-1:0]       r_addr;
  logic [lat_p-1:0][lanes_p-1:0]     r_p_m;
  logic [lat_p-1:0][lanes_p-1:0][LaW-1:0] r_p_a;
  logic                              r_done;

  logic                              w_accept;
  logic [VlW-1:0]                    w_vl_clamp;
  int                                w_ba;
  int                                w_beat_k;
  logic [VlW-1:0]                    w_beat_vl;
  logic                              w_load;
  logic                              w_done;
  logic                              w_up_busy;
  logic [lanes_p-1:0]                w_nxt_v;
  logic [lanes_p-1:0][LaW-1:0]       w_nxt_addr;

  // Handshake: an op transfers on the rising edge where v_i && ready_o; ready_o is
  // high only in IDLE, and upstream holds the op stable while ready_o is low.
  assign w_accept = v_i && (r_state == IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_beat_k    = 0;
    w_beat_vl   = r_vl;
    w_vl_clamp  = (int'(vl_i) > vlen_p) ? VlW'(vlen_p) : vl_i;
    w_ba        = (int'(w_vl_clamp) + lanes_p - 1) / lanes_p;
    // Every issued beat has at least one active lane, so a zero mask marks an empty slot.
    w_up_busy   = |r_rd_v;
    for (int j = 0; j < lat_p - 1; j++) begin
      w_up_busy = w_up_busy | (|r_p_m[j]);
    end
    case (r_state)
      IDLE: begin
        if (v_i) begin
          w_beat_vl = w_vl_clamp;
          // An empty op has nothing to drain, so it completes straight from IDLE.
          if (w_ba == 0) begin
            w_done = 1'b1;
          end else begin
            w_state_nxt = READ;
            w_load      = 1'b1;
          end
        end
      end
      READ: begin
        if (r_k == r_last_k) begin
          w_state_nxt = DRAIN;
        end else begin
          w_load   = 1'b1;
          w_beat_k = int'(r_k) + 1;
        end
      end
      DRAIN: begin
        if (!w_up_busy) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    for (int i = 0; i < lanes_p; i++) begin
      w_nxt_addr[i] = LaW'(w_beat_k * lanes_p + i);
      w_nxt_v[i]    = (w_beat_k * lanes_p + i) < int'(w_beat_vl);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_k      <= '0;
      r_last_k <= '0;
      r_vl     <= '0;
      r_vd     <= '0;
      r_vs1    <= '0;
      r_vs2    <= '0;
      r_rd_v   <= '0;
      r_addr   <= '0;
      r_p_m    <= '0;
      r_p_a    <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_vd     <= vd_i;
        r_vs1    <= vs1_i;
        r_vs2    <= vs2_i;
        r_vl     <= w_vl_clamp;
        r_last_k <= KW'(w_ba - 1);
        r_k      <= '0;
      end else if (r_state == READ && r_k != r_last_k) begin
        r_k <= r_k + KW'(1);
      end
      r_rd_v <= w_load ? w_nxt_v : '0;
      r_addr <= w_load ? w_nxt_addr : '0;
      // Write controls trail the read beat by exactly lat_p cycles.
      r_p_m[0] <= r_rd_v;
      r_p_a[0] <= r_addr;
      for (int j = 1; j < lat_p; j++) begin
        r_p_m[j] <= r_p_m[j-1];
        r_p_a[j] <= r_p_a[j-1];
      end
      r_done <= w_done;
    end
  end

  assign ready_o       = (r_state == IDLE);
  assign busy_o        = (r_state != IDLE);
  assign dbg_state_o   = r_state;
  assign done_o        = r_done;
  assign r_reg0_addr_o = r_vs1;
  assign r_reg1_addr_o = r_vs2;
  assign r_addr_o      = r_addr;
  assign rd_v_o        = r_rd_v;
  assign w_reg_addr_o  = r_vd;
  assign w_addr_o      = r_p_a[lat_p-1];
  assign w_en_o        = r_p_m[lat_p-1];

endmodule

// File: tb/tb_vrf_seq.sv
// Bench for vrf_seq: a per-op model predicts read beats, write beats and done
// cycles into queues; a negedge monitor pops and compares whatever the DUT shows.
module tb_vrf_seq;

  localparam int Lanes = 4;
  localparam int Vlen  = 8;
  localparam int Lat   = 2;
  localparam int RW    = 42;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            v_i = 1'b0;
  logic            ready_o;
  logic [4:0]      vd_i = '0;
  logic [4:0]      vs1_i = '0;
  logic [4:0]      vs2_i = '0;
  logic [3:0]      vl_i = '0;
  logic [4:0]      r_reg0_addr_o;
  logic [4:0]      r_reg1_addr_o;
  logic [3:0][2:0] r_addr_o;
  logic [3:0]      rd_v_o;
  logic [4:0]      w_reg_addr_o;
  logic [3:0][2:0] w_addr_o;
  logic [3:0]      w_en_o;
  logic            busy_o;
  logic            done_o;
  logic [1:0]      dbg_state_o;

  vrf_seq #(.els_p(32), .vlen_p(Vlen), .lanes_p(Lanes), .lat_p(Lat)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(ready_o),
    .vd_i(vd_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .vl_i(vl_i),
    .r_reg0_addr_o(r_reg0_addr_o), .r_reg1_addr_o(r_reg1_addr_o),
    .r_addr_o(r_addr_o), .rd_v_o(rd_v_o), .w_reg_addr_o(w_reg_addr_o),
    .w_addr_o(w_addr_o), .w_en_o(w_en_o), .busy_o(busy_o), .done_o(done_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_rd_q[$];
  logic [RW-1:0] exp_wr_q[$];
  int            exp_done_q[$];
  int            tests = 0;
  int            fails = 0;
  int            free_cycle = 0;
  int            hs_cycle = -1;

  logic [51:0] all_outs;
  logic [51:0] exp_reset_outs;
  assign all_outs = {ready_o, busy_o, done_o, r_reg0_addr_o, r_reg1_addr_o, r_addr_o,
                     rd_v_o, w_reg_addr_o, w_addr_o, w_en_o, dbg_state_o};
  assign exp_reset_outs = {1'b1, 51'd0};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Reference model: an op handshaken in cycle t with vl elements reads beat k at
  // t+1+k, writes it Lat cycles later, and reports done one cycle after the last write.
  task automatic model_op(input int t, input logic [4:0] vd, input logic [4:0] vs1,
                          input logic [4:0] vs2, input int vl);
    int vlc;
    int nb;
    logic [3:0]  m;
    logic [11:0] a;
    vlc = (vl > Vlen) ? Vlen : vl;
    nb  = (vlc + Lanes - 1) / Lanes;
    for (int k = 0; k < nb; k++) begin
      m = '0;
      a = '0;
      for (int i = 0; i < Lanes; i++) begin
        a[i*3 +: 3] = 3'(k * Lanes + i);
        m[i]        = (k * Lanes + i) < vlc;
      end
      exp_rd_q.push_back({16'(t + 1 + k), vs1, vs2, m, a});
      exp_wr_q.push_back({16'(t + 1 + k + Lat), vd, 5'd0, m, a});
    end
    free_cycle = (nb == 0) ? t + 1 : t + nb + Lat + 1;
    exp_done_q.push_back(free_cycle);
    hs_cycle = t;
  endtask

  // ---------------- driver tasks (run at posedge + 1) ----------------
  task automatic send_op(input logic [4:0] vd, input logic [4:0] vs1,
                         input logic [4:0] vs2, input int vl);
    vd_i  = vd;
    vs1_i = vs1;
    vs2_i = vs2;
    vl_i  = 4'(vl);
    v_i   = 1'b1;
    while (cyc < free_cycle) begin
      @(posedge clk);
      #1;
    end
    model_op(cyc, vd, vs1, vs2, vl);
    @(posedge clk);
    #1;
    v_i   = 1'b0;
    vd_i  = 5'($urandom_range(0, 31));
    vs1_i = 5'($urandom_range(0, 31));
    vs2_i = 5'($urandom_range(0, 31));
    vl_i  = 4'($urandom_range(0, 15));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- monitor ----------------
  logic [RW-1:0] obs_rd;
  logic [RW-1:0] obs_wr;
  logic [RW-1:0] head;
  logic          due;
  logic          exp_ready;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_outs", 64'(all_outs), 64'(exp_reset_outs));
    end else begin
      exp_ready = (cyc >= free_cycle) || (cyc == hs_cycle);
      check("ready", 64'(ready_o), 64'(exp_ready));
      check("busy", 64'(busy_o), 64'(!exp_ready));

      obs_rd = {16'(cyc), r_reg0_addr_o, r_reg1_addr_o, rd_v_o, r_addr_o};
      due = 1'b0;
      if (exp_rd_q.size() > 0) begin
        head = exp_rd_q[0];
        due  = (head[41:26] == 16'(cyc));
      end
      if (due || (|rd_v_o)) begin
        if (due) begin
          head = exp_rd_q.pop_front();
          check("read_beat", 64'(obs_rd), 64'(head));
        end else begin
          check("read_unexpected", 64'(rd_v_o), 64'd0);
        end
      end

      obs_wr = {16'(cyc), w_reg_addr_o, 5'd0, w_en_o, w_addr_o};
      due = 1'b0;
      if (exp_wr_q.size() > 0) begin
        head = exp_wr_q[0];
        due  = (head[41:26] == 16'(cyc));
      end
      if (due || (|w_en_o)) begin
        if (due) begin
          head = exp_wr_q.pop_front();
          check("write_beat", 64'(obs_wr), 64'(head));
        end else begin
          check("write_unexpected", 64'(w_en_o), 64'd0);
        end
      end

      due = (exp_done_q.size() > 0) && (exp_done_q[0] == cyc);
      if (due || done_o) begin
        if (due) begin
          void'(exp_done_q.pop_front());
          check("done", 64'(done_o), 64'd1);
        end else begin
          check("done_unexpected", 64'(done_o), 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    send_op(5'd3, 5'd1, 5'd2, 8);      // full op
    idle(6);
    send_op(5'd4, 5'd5, 5'd6, 5);      // partial last beat
    idle(6);
    send_op(5'd7, 5'd8, 5'd9, 0);      // empty op
    idle(2);
    send_op(5'd3, 5'd3, 5'd2, 15);     // clamp plus vd aliasing vs1
    idle(6);
    send_op(5'd10, 5'd11, 5'd12, 8);   // back-to-back chain
    send_op(5'd13, 5'd14, 5'd15, 6);
    send_op(5'd1, 5'd2, 5'd3, 0);
    send_op(5'd5, 5'd6, 5'd7, 3);
    send_op(5'd8, 5'd9, 5'd10, 4);
    idle(6);

    // Reset in the middle of an op: everything pending is dropped.
    send_op(5'd3, 5'd1, 5'd2, 8);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_done_q.delete();
    free_cycle = 0;
    hs_cycle   = -1;
    #1;
    check("reset_immediate", 64'(all_outs), 64'(exp_reset_outs));
    idle(2);
    reset_n = 1'b1;
    send_op(5'd20, 5'd21, 5'd22, 7);
    idle(6);

    for (int n = 0; n < 60; n++) begin
      send_op(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
      idle(int'($urandom_range(0, 3)));
    end

    while (cyc <= free_cycle + 3) begin
      @(posedge clk);
      #1;
    end
    check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
    check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
